// File: rtl/batched_matmul_engine_if.sv
// Operand and result streams of batched_matmul_engine.
// slave is the engine side, master is the surrounding pipeline side.
interface batched_matmul_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              out_job_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_job_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_job_last
    );
endinterface

// File: rtl/batched_matmul_engine.sv
// Batched signed matrix multiply C[b] = A[b] x B[b] with one sequential MAC per C element.
// Define BMM_SAT_OUT_EN to saturate results to signed OUT_W; otherwise results wrap.
module batched_matmul_engine #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned M       = 4,
    parameter int unsigned K       = 4,
    parameter int unsigned N       = 4,
    parameter int unsigned BATCH_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BATCH_W-1:0]     cfg_batches,
    output logic                   busy,
    output logic                   done,
    batched_matmul_engine_if.slave bus
);
    localparam int unsigned NA = M * K;
    localparam int unsigned NB = K * N;
    localparam int unsigned NL = NA + NB;
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned AW = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned LW = $clog2(NL);

`ifdef BMM_SAT_OUT_EN
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StMac, StEmit} state_e;

    state_e                    state_q;
    logic [BATCH_W-1:0]        nbatch_q, batch_q;
    logic [LW-1:0]             ld_q;
    logic [IW-1:0]             i_q;
    logic [JW-1:0]             j_q;
    logic [KW-1:0]             k_q;
    logic signed [ACC_W-1:0]   acc_q, acc_base, acc_d;
    logic signed [DATA_W-1:0]  a_q [NA];
    logic signed [DATA_W-1:0]  b_q [NB];
    logic                      busy_q, done_q, in_ready_q;
    logic                      out_valid_q, out_last_q, out_job_last_q;
    logic [OUT_W-1:0]          out_data_q, res_d;
    logic [AW-1:0]             a_idx;
    logic [BW-1:0]             b_idx;
    logic signed [2*DATA_W-1:0] prod;
    logic                      in_hs, out_hs, last_i, last_j, last_k, last_ld, elem_last;

    assign in_hs     = bus.in_valid && in_ready_q;
    assign out_hs    = out_valid_q && bus.out_ready;
    assign last_i    = (i_q == IW'(M - 1));
    assign last_j    = (j_q == JW'(N - 1));
    assign last_k    = (k_q == KW'(K - 1));
    assign last_ld   = (ld_q == LW'(NL - 1));
    assign elem_last = last_i && last_j;

    always_comb begin
        a_idx    = AW'(int'(i_q) * int'(K) + int'(k_q));
        b_idx    = BW'(int'(k_q) * int'(N) + int'(j_q));
        prod     = a_q[a_idx] * b_q[b_idx];
        acc_base = (k_q == '0) ? '0 : acc_q;
        acc_d    = acc_base + ACC_W'(prod);
`ifdef BMM_SAT_OUT_EN
        if (acc_d > SatMax) begin
            res_d = SatMax[OUT_W-1:0];
        end else if (acc_d < SatMin) begin
            res_d = SatMin[OUT_W-1:0];
        end else begin
            res_d = acc_d[OUT_W-1:0];
        end
`else
        res_d = acc_d[OUT_W-1:0];
`endif
    end

    // Operand buffers: the first NA beats of a batch are A, the rest are B, both row-major.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            if (ld_q < LW'(NA)) begin
                a_q[AW'(ld_q)] <= bus.in_data;
            end else begin
                b_q[BW'(ld_q - LW'(NA))] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            nbatch_q       <= '0;
            batch_q        <= '0;
            ld_q           <= '0;
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            out_job_last_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_batches != '0) begin
                            nbatch_q   <= cfg_batches;
                            batch_q    <= '0;
                            ld_q       <= '0;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= StLoad;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (in_hs) begin
                        if (last_ld) begin
                            ld_q       <= '0;
                            k_q        <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= StMac;
                        end else begin
                            ld_q <= ld_q + LW'(1);
                        end
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    if (last_k) begin
                        k_q            <= '0;
                        out_valid_q    <= 1'b1;
                        out_data_q     <= res_d;
                        out_last_q     <= elem_last;
                        out_job_last_q <= elem_last && (batch_q == nbatch_q - BATCH_W'(1));
                        state_q        <= StEmit;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                StEmit: begin
                    if (out_hs) begin
                        out_valid_q    <= 1'b0;
                        out_last_q     <= 1'b0;
                        out_job_last_q <= 1'b0;
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= last_i ? '0 : i_q + IW'(1);
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                        if (elem_last) begin
                            batch_q <= batch_q + BATCH_W'(1);
                            if (out_job_last_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                in_ready_q <= 1'b1;
                                state_q    <= StLoad;
                            end
                        end else begin
                            state_q <= StMac;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_job_last = out_job_last_q;
endmodule
